mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle main control FSM for the MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives all datapath enables and muxes, including the 2-bit aluctr code consumed by the downstream ALU-control decoder.
- Opcode comes from the datapath instruction register; zero comes from the ALU.

Parameters:
- CNT_W, 16, width of the retired-instruction counter instret.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- opcode  input  6  IR[31:26]; sampled in DECODE and later states only.
- zero  input  1  ALU zero flag.
- pcwrite  output  1  unconditional PC write.
- pcwritecond  output  1  PC write if zero.
- pc_en  output  1  pcwrite | (pcwritecond & zero).
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- memread  output  1  memory read strobe.
- memwrite  output  1  memory write strobe.
- irwrite  output  1  IR load enable.
- memtoreg  output  1  register write data: 1 = MDR, 0 = ALUOut.
- regdst  output  1  destination register: 1 = rd, 0 = rt.
- regwrite  output  1  register file write enable.
- alusrca  output  1  ALU A: 0 = PC, 1 = reg A.
- alusrcb  output  2  ALU B: 00 = reg B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- aluctr  output  2  00 = add, 01 = sub, 10 = R-type funct decode.
- pcsource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  output  4  current state code (debug).
- illegal_op  output  1  one-cycle pulse on an unknown opcode.
- instret  output  CNT_W  count of retired instructions.

Behaviour:
- All state updates occur on the rising clk edge. rst_n is sampled only at the edge.
- Reset (rst_n = 0 at an edge) takes priority over everything, including mid-instruction. It forces:
  - state = FETCH (0)
  - instret = 0
  - illegal_op = 0
- Control outputs are Moore, decoded combinationally from state. After reset they equal the FETCH values. Any control output not listed for a state is 0.
- States, asserted outputs and next state:
  - FETCH (0): memread, irwrite, pcwrite; alusrcb = 01; aluctr = 00. Next: DECODE.
  - DECODE (1): alusrcb = 11; aluctr = 00. Next by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - anything else -> FETCH, with illegal_op = 1 on the next cycle only
  - MEMADR (2): alusrca = 1; alusrcb = 10; aluctr = 00. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD (3): memread; iord = 1. Next: MEMWB.
  - MEMWB (4): regwrite; memtoreg = 1; regdst = 0. Next: FETCH.
  - MEMWR (5): memwrite; iord = 1. Next: FETCH.
  - EXEC (6): alusrca = 1; alusrcb = 00; aluctr = 10. Next: RWB.
  - RWB (7): regwrite; regdst = 1; memtoreg = 0. Next: FETCH.
  - BRANCH (8): alusrca = 1; alusrcb = 00; aluctr = 01; pcwritecond; pcsource = 01. Next: FETCH.
  - JUMP (9): pcwrite; pcsource = 10. Next: FETCH.
- Unused state codes (including 10/11 when the optional feature is off) go to FETCH on the next edge. All outputs are 0 while in an unused code.
- Cycles per instruction:
  - lw: 5
  - sw, R-type: 4
  - beq, j: 3
  - illegal opcode: 2
- instret increments by 1 on the edge leaving MEMWB, MEMWR, RWB, BRANCH, JUMP or IMMWB. It does not increment for an illegal opcode. It wraps from 2^CNT_W-1 to 0.
- The opcode value in FETCH is don't-care. Opcode must stay stable from DECODE until the instruction's last state.

Optional Feature:
- Macro MC_CTRL_ADDI_EN.
- When defined, opcode 001000 (addi) in DECODE goes to IMMEX:
  - IMMEX (10): alusrca = 1; alusrcb = 10; aluctr = 00. Next: IMMWB.
  - IMMWB (11): regwrite; regdst = 0; memtoreg = 0. Next: FETCH; instret increments.
- When undefined, 001000 is treated as illegal: DECODE -> FETCH with an illegal_op pulse. States 10/11 are unused codes.

Test Plan:
- Reset then lw (100011) -> state sequence 0,1,2,3,4,0 over 5 cycles; memread = 1 in states 0 and 3; regwrite = 1 only in state 4; instret goes 0 -> 1.
- sw (101011) -> states 0,1,2,5,0; memwrite = 1 for exactly one cycle with iord = 1; regwrite never asserted.
- R-type (000000) -> aluctr = 10 in EXEC; RWB has regdst = 1 and regwrite = 1; 4 cycles total.
- beq (000100) with zero = 1 -> pc_en = 1 in BRANCH with pcsource = 01 and aluctr = 01. Same sequence with zero = 0 -> pc_en = 0 in BRANCH.
- Opcode 111111 -> DECODE -> FETCH; illegal_op = 1 for one cycle; instret unchanged. With MC_CTRL_ADDI_EN, opcode 001000 -> states 1,10,11,0 and instret increments. Without the macro, 001000 -> illegal_op pulse.
- rst_n = 0 at the edge while in MEMRD -> next state FETCH and instret = 0. Also preload instret = 0xFFFF (CNT_W = 16), retire j -> instret = 0.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle MIPS main controller (master) and the datapath (slave).
// Carries the IR opcode and ALU zero flag in; enables, mux selects and debug/status out.
interface mc_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic             zero;
  logic             pcwrite;
  logic             pcwritecond;
  logic             pc_en;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             memtoreg;
  logic             regdst;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluctr;
  logic [1:0]       pcsource;
  logic [3:0]       state;
  logic             illegal_op;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, zero,
    output pcwrite, pcwritecond, pc_en, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluctr, pcsource,
           state, illegal_op, instret
  );

  modport slave (
    output opcode, zero,
    input  pcwrite, pcwritecond, pc_en, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluctr, pcsource,
           state, illegal_op, instret
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main control FSM: Moore decode of datapath controls plus retired-instruction counter.
// Optional addi support (IMMEX/IMMWB states) is enabled by defining MC_CTRL_ADDI_EN.
module mc_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  mc_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IMMEX  = 4'd10,
    IMMWB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_CTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  state_t           state_r;
  state_t           state_nxt;
  logic             illegal_r;
  logic             illegal_nxt;
  logic             retire;
  logic [CNT_W-1:0] instret_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= FETCH;
      illegal_r <= 1'b0;
      instret_r <= '0;
    end else begin
      state_r   <= state_nxt;
      illegal_r <= illegal_nxt;
      if (retire) begin
        instret_r <= instret_r + CNT_W'(1);
      end
    end
  end

  // Next state; retire marks the last state of every legal instruction
  always_comb begin
    state_nxt   = FETCH;
    illegal_nxt = 1'b0;
    retire      = 1'b0;
    case (state_r)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = EXEC;
          OP_BEQ:       state_nxt = BRANCH;
          OP_J:         state_nxt = JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_nxt = IMMEX;
`endif
          default:      illegal_nxt = 1'b1;
        endcase
      end
      MEMADR: state_nxt = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_nxt = MEMWB;
      EXEC:   state_nxt = RWB;
      MEMWB, MEMWR, RWB, BRANCH, JUMP: retire = 1'b1;
`ifdef MC_CTRL_ADDI_EN
      IMMEX:  state_nxt = IMMWB;
      IMMWB:  retire = 1'b1;
`endif
      default: ;
    endcase
  end

  // Moore output decode; unused state codes leave every control at 0
  always_comb begin
    bus.pcwrite     = 1'b0;
    bus.pcwritecond = 1'b0;
    bus.iord        = 1'b0;
    bus.memread     = 1'b0;
    bus.memwrite    = 1'b0;
    bus.irwrite     = 1'b0;
    bus.memtoreg    = 1'b0;
    bus.regdst      = 1'b0;
    bus.regwrite    = 1'b0;
    bus.alusrca     = 1'b0;
    bus.alusrcb     = 2'b00;
    bus.aluctr      = 2'b00;
    bus.pcsource    = 2'b00;
    case (state_r)
      FETCH: begin
        bus.memread = 1'b1;
        bus.irwrite = 1'b1;
        bus.pcwrite = 1'b1;
        bus.alusrcb = 2'b01;
      end
      DECODE: bus.alusrcb = 2'b11;
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      MEMRD: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
      end
      MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
      end
      MEMWR: begin
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
      end
      EXEC: begin
        bus.alusrca = 1'b1;
        bus.aluctr  = 2'b10;
      end
      RWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
      end
      BRANCH: begin
        bus.alusrca     = 1'b1;
        bus.aluctr      = 2'b01;
        bus.pcwritecond = 1'b1;
        bus.pcsource    = 2'b01;
      end
      JUMP: begin
        bus.pcwrite  = 1'b1;
        bus.pcsource = 2'b10;
      end
`ifdef MC_CTRL_ADDI_EN
      IMMEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      IMMWB: bus.regwrite = 1'b1;
`endif
      default: ;
    endcase
  end

  assign bus.pc_en      = bus.pcwrite | (bus.pcwritecond & bus.zero);
  assign bus.state      = state_r;
  assign bus.illegal_op = illegal_r;
  assign bus.instret    = instret_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle state/control checks for each instruction class,
// reset behaviour, illegal opcodes and counter wrap (on a narrow-counter second instance).
module tb_mc_ctrl;
  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic rst_w_n = 1'b0;
  int   n_cmp   = 0;
  int   n_err   = 0;

  always #5 clk = ~clk;

  mc_ctrl_if #(.CNT_W(16)) bus ();
  mc_ctrl_if #(.CNT_W(4))  wbus ();

  mc_ctrl #(.CNT_W(16)) dut   (.clk(clk), .rst_n(rst_n),   .bus(bus));
  mc_ctrl #(.CNT_W(4))  dut_w (.clk(clk), .rst_n(rst_w_n), .bus(wbus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    bus.opcode  = 6'b000000;
    bus.zero    = 1'b0;
    wbus.opcode = 6'b000010;
    wbus.zero   = 1'b0;
    step();
    step();

    // Reset state: FETCH controls, counters cleared
    chk("rst_state",   bus.state,      0);
    chk("rst_instret", bus.instret,    0);
    chk("rst_illegal", bus.illegal_op, 0);
    chk("rst_memread", bus.memread,    1);
    chk("rst_irwrite", bus.irwrite,    1);
    chk("rst_pcwrite", bus.pcwrite,    1);
    chk("rst_alusrcb", bus.alusrcb,    1);
    chk("rst_aluctr",  bus.aluctr,     0);
    chk("rst_pc_en",   bus.pc_en,      1);

    // Wrap: 4-bit counter retiring back-to-back j (3 cycles each)
    rst_w_n = 1'b1;
    repeat (45) step();
    chk("wrap_15", wbus.instret, 15);
    repeat (3) step();
    chk("wrap_0", wbus.instret, 0);
    chk("held_rst_state", bus.state, 0);
    rst_n = 1'b1;

    // lw: 0,1,2,3,4
    bus.opcode = 6'b100011;
    chk("lw_s0", bus.state, 0);    chk("lw_s0_rw", bus.regwrite, 0);
    step(); chk("lw_s1", bus.state, 1);  chk("lw_s1_alusrcb", bus.alusrcb, 3);
    chk("lw_s1_rw", bus.regwrite, 0);
    step(); chk("lw_s2", bus.state, 2);  chk("lw_s2_alusrca", bus.alusrca, 1);
    chk("lw_s2_alusrcb", bus.alusrcb, 2); chk("lw_s2_rw", bus.regwrite, 0);
    step(); chk("lw_s3", bus.state, 3);  chk("lw_s3_memread", bus.memread, 1);
    chk("lw_s3_iord", bus.iord, 1);      chk("lw_s3_rw", bus.regwrite, 0);
    step(); chk("lw_s4", bus.state, 4);  chk("lw_s4_rw", bus.regwrite, 1);
    chk("lw_s4_memtoreg", bus.memtoreg, 1); chk("lw_s4_regdst", bus.regdst, 0);
    chk("lw_s4_instret", bus.instret, 0);
    step(); chk("lw_end", bus.state, 0); chk("lw_instret", bus.instret, 1);

    // sw: 0,1,2,5
    bus.opcode = 6'b101011;
    step(); chk("sw_s1", bus.state, 1);
    step(); chk("sw_s2", bus.state, 2);  chk("sw_s2_memwrite", bus.memwrite, 0);
    step(); chk("sw_s5", bus.state, 5);  chk("sw_s5_memwrite", bus.memwrite, 1);
    chk("sw_s5_iord", bus.iord, 1);      chk("sw_s5_rw", bus.regwrite, 0);
    step(); chk("sw_end", bus.state, 0); chk("sw_end_memwrite", bus.memwrite, 0);
    chk("sw_instret", bus.instret, 2);

    // R-type: 0,1,6,7
    bus.opcode = 6'b000000;
    step(); chk("r_s1", bus.state, 1);
    step(); chk("r_s6", bus.state, 6);   chk("r_s6_aluctr", bus.aluctr, 2);
    chk("r_s6_alusrca", bus.alusrca, 1); chk("r_s6_alusrcb", bus.alusrcb, 0);
    step(); chk("r_s7", bus.state, 7);   chk("r_s7_regdst", bus.regdst, 1);
    chk("r_s7_rw", bus.regwrite, 1);     chk("r_s7_memtoreg", bus.memtoreg, 0);
    step(); chk("r_end", bus.state, 0);  chk("r_instret", bus.instret, 3);

    // beq taken
    bus.opcode = 6'b000100;
    bus.zero   = 1'b1;
    step(); chk("beq1_s1", bus.state, 1); chk("beq1_s1_pc_en", bus.pc_en, 0);
    step(); chk("beq1_s8", bus.state, 8); chk("beq1_pc_en", bus.pc_en, 1);
    chk("beq1_pcsource", bus.pcsource, 1); chk("beq1_aluctr", bus.aluctr, 1);
    step(); chk("beq1_end", bus.state, 0); chk("beq1_instret", bus.instret, 4);

    // beq not taken
    bus.zero = 1'b0;
    step(); chk("beq0_s1", bus.state, 1);
    step(); chk("beq0_s8", bus.state, 8); chk("beq0_pc_en", bus.pc_en, 0);
    chk("beq0_pcwritecond", bus.pcwritecond, 1);
    step(); chk("beq0_end", bus.state, 0); chk("beq0_instret", bus.instret, 5);

    // j
    bus.opcode = 6'b000010;
    step(); chk("j_s1", bus.state, 1);
    step(); chk("j_s9", bus.state, 9);   chk("j_pcwrite", bus.pcwrite, 1);
    chk("j_pcsource", bus.pcsource, 2);  chk("j_pc_en", bus.pc_en, 1);
    step(); chk("j_end", bus.state, 0);  chk("j_instret", bus.instret, 6);

    // Illegal opcode: DECODE -> FETCH with a one-cycle pulse
    bus.opcode = 6'b111111;
    chk("ill_pre", bus.illegal_op, 0);
    step(); chk("ill_s1", bus.state, 1); chk("ill_s1_pulse", bus.illegal_op, 0);
    step(); chk("ill_s0", bus.state, 0); chk("ill_pulse", bus.illegal_op, 1);
    chk("ill_instret", bus.instret, 6);
    step(); chk("ill_pulse_off", bus.illegal_op, 0);
    step(); chk("ill2_s0", bus.state, 0);

    // addi
    bus.opcode = 6'b001000;
    step(); chk("addi_s1", bus.state, 1);
`ifdef MC_CTRL_ADDI_EN
    step(); chk("addi_s10", bus.state, 10); chk("addi_s10_alusrcb", bus.alusrcb, 2);
    chk("addi_s10_alusrca", bus.alusrca, 1);
    step(); chk("addi_s11", bus.state, 11); chk("addi_s11_rw", bus.regwrite, 1);
    chk("addi_s11_regdst", bus.regdst, 0);  chk("addi_s11_memtoreg", bus.memtoreg, 0);
    step(); chk("addi_end", bus.state, 0);  chk("addi_instret", bus.instret, 7);
    chk("addi_no_ill", bus.illegal_op, 0);
`else
    step(); chk("addi_s0", bus.state, 0); chk("addi_ill", bus.illegal_op, 1);
    chk("addi_instret", bus.instret, 6);
`endif

    // Reset taken mid-instruction in MEMRD
    bus.opcode = 6'b100011;
    step(); chk("mr_s1", bus.state, 1);
    step(); chk("mr_s2", bus.state, 2);
    step(); chk("mr_s3", bus.state, 3);
    rst_n = 1'b0;
    step(); chk("mr_rst_state", bus.state, 0); chk("mr_rst_instret", bus.instret, 0);
    chk("mr_rst_illegal", bus.illegal_op, 0);
    rst_n = 1'b1;
    step(); chk("post_rst_s1", bus.state, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
